tdc_launch_capture: RTL and testbench
=====================================

Name: tdc_launch_capture

Overview:
- Initiator/reader side of the time-to-digital converter tile.
- Generates the launch edge that the TDC delay line measures and the capture strobe that freezes it.
- Reads back the thermometer snapshot, decodes it to a tap count and accumulates N samples.
- Presents the sum with a valid/ready handshake to the container's readout logic.

Parameters:
- TAP_W, 8, width of the thermometer snapshot from the TDC
- GAP_W, 4, width of the launch-to-capture gap setting
- ACC_W, 12, accumulator/result width; must satisfy 2^ACC_W > 16*TAP_W (elaboration-time check)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  begin a measurement burst; honoured only in IDLE
- nsamp_i  input  4  samples per burst minus one (0 -> 1 sample, 15 -> 16 samples); latched on accepted start
- gap_i  input  GAP_W  extra cycles between launch and capture; latched on accepted start
- launch_o  output  1  launch edge to the TDC start input
- capture_o  output  1  capture clock/strobe to the TDC
- therm_i  input  TAP_W  thermometer snapshot returned by the TDC
- busy_o  output  1  high in every state except IDLE
- result_o  output  ACC_W  sum of decoded tap counts; valid while valid_o=1
- err_o  output  1  bubble seen in any sample of the burst; valid with result_o
- valid_o  output  1  result available
- ready_i  input  1  consumer accepts the result

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - launch_o, capture_o, busy_o, valid_o, err_o = 0; result_o = 0.
  - Sample counter, gap counter and latched settings = 0.
  - Reset mid-burst aborts it; no partial result is presented.
- States: IDLE, LAUNCH, WAIT, CAPTURE, SAMPLE, DONE. All outputs are registered decodes of state.
- IDLE: on start_i=1, latch nsamp_i/gap_i, clear accumulator and err, go to LAUNCH.
- LAUNCH: launch_o=1 for exactly 1 cycle; load gap counter with gap; go to WAIT if gap!=0, else CAPTURE.
- WAIT: launch_o=1 (edge held); decrement gap counter; go to CAPTURE when it reaches 1.
- CAPTURE: launch_o=1, capture_o=1 for exactly 1 cycle.
- SAMPLE:
  - launch_o=0, capture_o=0. This guarantees at least one low cycle between launches.
  - therm_i is registered in this cycle.
  - Decode: d = number of contiguous ones starting at bit 0 (range 0..TAP_W).
  - Bubble: any 1 above the first 0; sets err sticky for the burst.
  - acc += d, zero-extended to ACC_W.
  - If samples done == nsamp+1, go to DONE; else go to LAUNCH.
- Per-sample period is 3+gap cycles.
- Latency: if start_i is accepted at edge k, valid_o is first high in cycle k+1+(nsamp+1)*(3+gap).
  - Example: nsamp=0, gap=0 -> valid_o high 4 cycles after start.
- DONE: valid_o=1; result_o=acc and err_o=err held stable until valid_o&ready_i. Return to IDLE on the next edge; valid_o drops that edge.
- start_i outside IDLE is ignored, including in the DONE handshake cycle. The earliest new start is taken in the first IDLE cycle.
- Changes on nsamp_i/gap_i during a burst have no effect.
- gap=2^GAP_W-1 (max) is legal; no wrap of the gap counter.
- Overflow: none possible given the ACC_W constraint. Max sum is 16*TAP_W = 128 for defaults.
- therm_i is treated as asynchronous to the FSM only through the TDC capture. No synchronizer here; the container places one if required.

Test Plan:
- Reset mid-WAIT (gap=10, rst asserted in 4th WAIT cycle) -> next cycle: launch_o=0, busy_o=0, valid_o=0, result_o=0; new start runs a clean burst.
- Single sample, nsamp=0, gap=0, therm_i=8'b0000_0111 -> launch_o high 2 cycles then low, capture_o one pulse, valid_o at start+4, result_o=3, err_o=0.
- 16 samples, nsamp=15, gap=3, therm_i=8'hFF constant -> exactly 16 launch pulses each 5 cycles high with 1 low cycle between; valid_o at start+1+16*6=start+97; result_o=128; err_o=0.
- Bubble: nsamp=1, samples 8'b0001_0011 then 8'b0000_0001 -> result_o=3, err_o=1; next clean burst -> err_o=0.
- Backpressure: ready_i=0 for 20 cycles in DONE with start_i pulsed -> valid_o/result_o stable, start ignored, no launch; ready_i=1 -> IDLE next cycle, then start accepted.
- therm_i=8'h00, nsamp=3, gap=1 -> result_o=0, err_o=0, valid_o at start+17.

Source files
------------

// File: rtl/tdc_launch_capture.sv
// Launch/capture sequencer and thermometer reader for the TDC tile.
// Runs bursts of N launch/capture samples, decodes each snapshot and presents the sum.
module tdc_launch_capture #(
    parameter int TAP_W = 8,
    parameter int GAP_W = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       nsamp_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             launch_o,
    output logic             capture_o,
    input  logic [TAP_W-1:0] therm_i,
    output logic             busy_o,
    output logic [ACC_W-1:0] result_o,
    output logic             err_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int CNT_W = $clog2(TAP_W + 1);

    if ((2 ** ACC_W) <= (16 * TAP_W)) begin : g_acc_w_check
        $error("tdc_launch_capture: ACC_W too small to hold 16*TAP_W");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SAMPLE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Length of the unbroken run of ones starting at tap 0.
    function automatic logic [CNT_W-1:0] therm_count(input logic [TAP_W-1:0] t);
        logic             run;
        logic [CNT_W-1:0] n;
        run = 1'b1;
        n   = {CNT_W{1'b0}};
        for (int i = 0; i < TAP_W; i++) begin
            if (run && t[i]) begin
                n = n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // Any one sitting above the first zero is a bubble in the delay line.
    function automatic logic therm_bubble(input logic [TAP_W-1:0] t);
        logic zero_seen;
        logic b;
        zero_seen = 1'b0;
        b         = 1'b0;
        for (int i = 0; i < TAP_W; i++) begin
            b         = b | (t[i] & zero_seen);
            zero_seen = zero_seen | ~t[i];
        end
        return b;
    endfunction

    state_t             state_q,    state_d;
    logic [3:0]         nsamp_q,    nsamp_d;
    logic [GAP_W-1:0]   gap_q,      gap_d;
    logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
    logic [3:0]         samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic               err_q,      err_d;
    logic [ACC_W-1:0]   result_q,   result_d;
    logic               err_out_q,  err_out_d;
    logic               launch_q,   launch_d;
    logic               capture_q,  capture_d;
    logic               busy_q,     busy_d;
    logic               valid_q,    valid_d;
    logic [ACC_W-1:0]   acc_sum_s;
    logic               err_sum_s;

    assign acc_sum_s = acc_q + ACC_W'(therm_count(therm_i));
    assign err_sum_s = err_q | therm_bubble(therm_i);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        nsamp_d    = nsamp_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        samp_cnt_d = samp_cnt_q;
        acc_d      = acc_q;
        err_d      = err_q;
        result_d   = result_q;
        err_out_d  = err_out_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    nsamp_d    = nsamp_i;
                    gap_d      = gap_i;
                    samp_cnt_d = 4'd0;
                    acc_d      = {ACC_W{1'b0}};
                    err_d      = 1'b0;
                    state_d    = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                gap_cnt_d = gap_q;
                if (gap_q != {GAP_W{1'b0}}) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_CAPTURE: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                acc_d = acc_sum_s;
                err_d = err_sum_s;
                if (samp_cnt_q == nsamp_q) begin
                    result_d  = acc_sum_s;
                    err_out_d = err_sum_s;
                    state_d   = S_DONE;
                end else begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                    state_d    = S_LAUNCH;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The launch edge stays high from LAUNCH through CAPTURE; SAMPLE is the low gap.
        launch_d  = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
        capture_d = (state_d == S_CAPTURE);
        busy_d    = (state_d != S_IDLE);
        valid_d   = (state_d == S_DONE);
    end

    // State, settings, accumulator and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nsamp_q    <= 4'd0;
            gap_q      <= {GAP_W{1'b0}};
            gap_cnt_q  <= {GAP_W{1'b0}};
            samp_cnt_q <= 4'd0;
            acc_q      <= {ACC_W{1'b0}};
            err_q      <= 1'b0;
            result_q   <= {ACC_W{1'b0}};
            err_out_q  <= 1'b0;
            launch_q   <= 1'b0;
            capture_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            nsamp_q    <= nsamp_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            result_q   <= result_d;
            err_out_q  <= err_out_d;
            launch_q   <= launch_d;
            capture_q  <= capture_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign launch_o  = launch_q;
    assign capture_o = capture_q;
    assign busy_o    = busy_q;
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign err_o     = err_out_q;

endmodule

// File: tb/tb_tdc_launch_capture.sv
// Scenario bench for tdc_launch_capture: a small TDC model feeds snapshots on capture,
// expected sums/latencies go into a scoreboard queue and are popped when valid_o rises.
module tb_tdc_launch_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  nsamp_i;
    logic [3:0]  gap_i;
    logic        launch_o;
    logic        capture_o;
    logic [7:0]  therm_i;
    logic        busy_o;
    logic [11:0] result_o;
    logic        err_o;
    logic        valid_o;
    logic        ready_i;

    typedef struct {
        logic [11:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pat_q[$];
    logic [7:0] therm_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    tdc_launch_capture dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .nsamp_i   (nsamp_i),
        .gap_i     (gap_i),
        .launch_o  (launch_o),
        .capture_o (capture_o),
        .therm_i   (therm_i),
        .busy_o    (busy_o),
        .result_o  (result_o),
        .err_o     (err_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    always #5 clk = ~clk;

    // TDC model: a new snapshot appears while the capture strobe is high.
    always @(negedge clk) begin
        if (capture_o && therm_q.size() > 0) begin
            therm_i = therm_q.pop_front();
        end
    end

    function automatic void model(input logic [7:0] t, output int d, output bit bub);
        d = 0;
        while (d < 8 && t[d]) d++;
        bub = ((t >> d) != 8'd0);
    endfunction

    // Runs one burst with the patterns in pat_q; hold>0 keeps ready_i low that many DONE cycles.
    task automatic do_burst(input logic [3:0] ns, input logic [3:0] gp, input int hold);
        exp_t e;
        int   sum, d, cyc, launches, hi, lo, bad_hi, bad_lo, caps;
        bit   bub, eb, prev_l, done;
        sum = 0;
        eb  = 1'b0;
        foreach (pat_q[i]) begin
            model(pat_q[i], d, bub);
            sum += d;
            eb  |= bub;
        end
        therm_q = pat_q;
        pat_q.delete();
        e.res = 12'(sum);
        e.err = eb;
        e.lat = 1 + (int'(ns) + 1) * (3 + int'(gp));
        sb.push_back(e);

        nsamp_i = ns;
        gap_i   = gp;
        ready_i = (hold == 0);
        start_i = 1'b1;
        cyc = 0; launches = 0; hi = 0; lo = 0; bad_hi = 0; bad_lo = 0; caps = 0;
        prev_l = 1'b0;
        done   = 1'b0;
        while (!done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start_i = 1'b0;
            nsamp_i = 4'hF - ns;
            gap_i   = 4'hF - gp;
            if (launch_o) begin
                if (!prev_l) begin
                    launches++;
                    if (launches > 1 && lo != 1) bad_lo++;
                    hi = 0;
                end
                hi++;
            end else begin
                if (prev_l) begin
                    if (hi != int'(gp) + 2) bad_hi++;
                    lo = 0;
                end
                lo++;
            end
            prev_l = launch_o;
            if (capture_o) caps++;
            if (valid_o) done = 1'b1;
        end

        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL burst_timeout: valid_o never rose after %0d cycles, required at cycle %0d", cyc, e.lat);
            if (sb.size() > 0) void'(sb.pop_front());
            ready_i = 1'b1;
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.lat) begin
            n_fail++;
            $display("FAIL latency: valid_o at cycle %0d, required %0d", cyc, e.lat);
        end
        n_checks++;
        if (result_o !== e.res) begin
            n_fail++;
            $display("FAIL result: got %0d, required %0d", result_o, e.res);
        end
        n_checks++;
        if (err_o !== e.err) begin
            n_fail++;
            $display("FAIL err: got %b, required %b", err_o, e.err);
        end
        n_checks++;
        if (launches != int'(ns) + 1 || caps != int'(ns) + 1) begin
            n_fail++;
            $display("FAIL pulse_count: launches %0d captures %0d, required %0d each", launches, caps, int'(ns) + 1);
        end
        n_checks++;
        if (bad_hi != 0 || bad_lo != 0) begin
            n_fail++;
            $display("FAIL launch_shape: %0d bad high runs, %0d bad low gaps, required 0 and 0", bad_hi, bad_lo);
        end

        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                start_i = (i % 3 == 0);
                @(posedge clk); #1;
                n_checks++;
                if (valid_o !== 1'b1 || result_o !== e.res || err_o !== e.err || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid %b result %0d err %b busy %b, required 1 %0d %b 1",
                             valid_o, result_o, err_o, busy_o, e.res, e.err);
                end
                n_checks++;
                if (launch_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_no_launch: launch_o %b, required 0", launch_o);
                end
            end
            start_i = 1'b1;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || launch_o !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_release: valid %b busy %b launch %b, required 0 0 0", valid_o, busy_o, launch_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; nsamp_i = 4'd0; gap_i = 4'd0; ready_i = 1'b1; therm_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (launch_o !== 1'b0 || capture_o !== 1'b0 || busy_o !== 1'b0 ||
            valid_o !== 1'b0 || err_o !== 1'b0 || result_o !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state: launch %b capture %b busy %b valid %b err %b result %0d, required all 0",
                     launch_o, capture_o, busy_o, valid_o, err_o, result_o);
        end
    endtask

    task automatic test_single();
        pat_q.push_back(8'b0000_0111);
        do_burst(4'd0, 4'd0, 0);
    endtask

    task automatic test_reset_mid_wait();
        nsamp_i = 4'd0; gap_i = 4'd10; start_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        n_checks++;
        if (busy_o !== 1'b1 || launch_o !== 1'b1 || capture_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait_state: busy %b launch %b capture %b, required 1 1 0", busy_o, launch_o, capture_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (launch_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 12'd0 || capture_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: launch %b busy %b valid %b result %0d capture %b, required 0 0 0 0 0",
                     launch_o, busy_o, valid_o, result_o, capture_o);
        end
        pat_q.push_back(8'h0F);
        do_burst(4'd0, 4'd2, 0);
    endtask

    task automatic test_sixteen();
        for (int i = 0; i < 16; i++) pat_q.push_back(8'hFF);
        do_burst(4'd15, 4'd3, 0);
    endtask

    task automatic test_bubble();
        pat_q.push_back(8'b0001_0011);
        pat_q.push_back(8'b0000_0001);
        do_burst(4'd1, 4'd0, 0);
        pat_q.push_back(8'b0000_0011);
        pat_q.push_back(8'b0000_0001);
        do_burst(4'd1, 4'd0, 0);
    endtask

    task automatic test_back_to_back();
        pat_q.push_back(8'h3F);
        pat_q.push_back(8'h1F);
        pat_q.push_back(8'hFF);
        do_burst(4'd2, 4'd1, 20);
        pat_q.push_back(8'h01);
        do_burst(4'd0, 4'd15, 0);
    endtask

    task automatic test_zero();
        for (int i = 0; i < 4; i++) pat_q.push_back(8'h00);
        do_burst(4'd3, 4'd1, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_wait();
        test_sixteen();
        test_bubble();
        test_back_to_back();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
